serial_bus_master: RTL and testbench
====================================

# serial_bus_master

UART-driven bus initiator: receives 8N1 command frames on a serial line and executes CPU-style chip-select/read/write cycles on the 4-bit-address peripheral bus, so a host PC can poke and peek peripheral registers without the Z80. It sits beside the CPU as an alternate bus master, driving the same ncs/nwr/nrd/addr/data signals that peripherals such as the serial port respond to. Read results are returned to the host as one 8N1 byte.

## Interface
- BAUD_DIV, 208: cpuclk cycles per bit (19200 bps at 4 MHz).
- SETUP_CYCLES, 1: cycles with ncs/addr/data valid before the strobe falls (≥1).
- STROBE_CYCLES, 4: cycles nwr/nrd held low (≥2).
- cpuclk  in  1  4 MHz system clock; all logic on posedge.
- nrst  in  1  synchronous active-low reset (reset nrst, synchronous, active-low; clock cpuclk).
- rxd_serial  in  1  host → block serial, idle high, asynchronous.
- txd_serial  out  1  block → host serial, idle high.
- bus_ncs  out  1  active-low chip select.
- bus_nwr  out  1  active-low write strobe.
- bus_nrd  out  1  active-low read strobe.
- bus_addr  out  4  register address.
- bus_data  inout  8  driven only during write cycles, else Z.
- busy  out  1  high from command byte accepted until bus cycle (and any read response) complete.
- err  out  1  one-cycle pulse on framing error, invalid command, or overrun.

## Operation
- rxd_serial passes a 2-flop synchronizer before use.
- RX FSM: IDLE → START on synced low; after BAUD_DIV/2 cycles resample: high → IDLE (glitch, no err); low → DATA. Sample 8 bits LSB first every BAUD_DIV cycles, then STOP sample after BAUD_DIV more. Stop low → byte discarded, err pulse, IDLE. Stop high → byte to 1-entry holding register; if holding register still full, new byte dropped, err pulse (overrun).
- Command byte: bit7 = 1 read / 0 write; bits6:4 must be 000, else byte ignored, err pulse; bits3:0 = address.
- Main FSM: CMD → (write) DATA_WAIT → SETUP → STROBE → HOLD → CMD; (read) TX_WAIT → SETUP → STROBE → HOLD → RESP → CMD.
- Write: next received byte is data, consumed unconditionally (no validity check).
- SETUP: bus_ncs=0, bus_addr=address, bus_data driven (writes), strobes high, SETUP_CYCLES cycles.
- STROBE: bus_nwr or bus_nrd low, STROBE_CYCLES cycles. Read data sampled on the posedge ending the last strobe cycle.
- HOLD: 1 cycle, strobe high, ncs still low, write data still driven. Then ncs=1, data Z; bus_addr keeps last value.
- TX_WAIT: read does not start its bus cycle while transmitter busy.
- RESP: load sampled byte to TX; TX sends start(0), 8 bits LSB first, stop(1), each BAUD_DIV cycles; TX busy until stop bit ends.
- Receiver runs continuously, independent of main FSM.

## Timing
- Reset values: txd_serial=1, bus_ncs=1, bus_nwr=1, bus_nrd=1, bus_addr=0, bus_data=Z, busy=0, err=0; all FSMs idle, holding register empty.
- Reset mid-cycle: strobes and ncs deassert on the reset edge; any TX frame aborts with txd_serial=1; no partial response later.
- Holding register consumed one cycle after it fills when FSM is in CMD/DATA_WAIT.
- Bus cycle length: ncs low SETUP_CYCLES+STROBE_CYCLES+1 = 6 cycles by default; strobe never low in first or last ncs-low cycle.
- bus_data enable rises with ncs fall, drops with ncs rise (write).
- busy rises the cycle after command byte consumed; falls the cycle after HOLD (write) or after TX stop bit (read).
- Read response starts on txd_serial within 2 cycles of HOLD exit.
- err pulse width exactly 1 cycle; simultaneous sources yield a single pulse.
- Baud counters 8-bit, count down to 0, reload BAUD_DIV-1.

## Test plan
- Write: host sends 0x09, 0x03 → addr=9, bus_data=0x03, ncs low 6 cycles, nwr low exactly 4 cycles starting 1 cycle after ncs fall; nrd stays high; no TX activity.
- Read: host sends 0x88, responder drives 0xA5 during strobe → nrd low 4 cycles, txd frame 0,1,0,1,0,0,1,0,1,1 each 208 cycles.
- Errors: frame with stop bit 0 → err pulse, no bus cycle; command 0x30 → err pulse, no bus cycle, next 0x88 works normally.
- Back-to-back reads 0x81, 0x82 sent with no gap → second bus cycle waits until first response stop bit ends; two correct response bytes in order.
- Glitch/reset: 50-cycle low pulse on rxd → no byte, no err; nrst low during STROBE of a write → nwr, ncs high on that edge, data Z, busy=0, txd=1.

Source files
------------

// File: rtl/serial_bus_master.sv
// UART-driven alternate bus master: 8N1 command frames from a host become
// ncs/nwr/nrd cycles on the 4-bit-address peripheral bus; reads are answered with one 8N1 byte.
//
// state        | meaning
// M_CMD        | idle, waiting for a command byte in the holding register
// M_DATA_WAIT  | write accepted, waiting for its data byte
// M_TX_WAIT    | read accepted, waiting for the transmitter to go idle
// M_SETUP      | ncs low, address (and write data) valid, strobes high
// M_STROBE     | nwr or nrd low
// M_HOLD       | strobe released, ncs still low
// M_RESP       | read byte handed to the transmitter
// M_RESP_WAIT  | response frame in flight
module serial_bus_master #(
  parameter int BAUD_DIV      = 208,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4
) (
  input  logic       cpuclk,
  input  logic       nrst,
  input  logic       rxd_serial,
  output logic       txd_serial,
  output logic       bus_ncs,
  output logic       bus_nwr,
  output logic       bus_nrd,
  output logic [3:0] bus_addr,
  inout  wire  [7:0] bus_data,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] BAUD_RELOAD   = 8'(BAUD_DIV - 1);
  localparam logic [7:0] HALF_RELOAD   = 8'(BAUD_DIV / 2 - 1);
  localparam logic [7:0] SETUP_RELOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_RELOAD = 8'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {
    M_CMD, M_DATA_WAIT, M_TX_WAIT, M_SETUP, M_STROBE, M_HOLD, M_RESP, M_RESP_WAIT
  } m_state_t;

  rx_state_t  rx_state, rx_next;
  tx_state_t  tx_state, tx_next;
  m_state_t   m_state, m_next;

  logic       rx_meta, rx_sync;
  logic [7:0] rx_cnt, rx_shift;
  logic [2:0] rx_bit;
  logic       rx_done, rx_frame_err, rx_overrun;
  logic       hold_full, hold_take;
  logic [7:0] hold_data;

  logic       cmd_err, is_read, tx_load, tx_busy, data_oe;
  logic [3:0] cmd_addr, addr_q;
  logic [7:0] wdata, rdata, phase_cnt;

  logic [7:0] tx_cnt, tx_shift;
  logic [2:0] tx_bit;

  always_ff @(posedge cpuclk) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd_serial;
      rx_sync <= rx_meta;
    end
  end

  // Receiver
  always_ff @(posedge cpuclk) begin
    if (!nrst) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next      = rx_state;
    rx_done      = 1'b0;
    rx_frame_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_sync) rx_next = RX_START;
      RX_START: if (rx_cnt == '0) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == '0 && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_cnt == '0) begin
        rx_next      = RX_IDLE;
        rx_done      = rx_sync;
        rx_frame_err = !rx_sync;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // A byte landing while the main FSM empties the register is not an overrun
  assign rx_overrun = rx_done && hold_full && !hold_take;

  always_ff @(posedge cpuclk) begin
    if (!nrst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE)  rx_cnt <= HALF_RELOAD;
      else if (rx_cnt == '0)    rx_cnt <= BAUD_RELOAD;
      else                      rx_cnt <= rx_cnt - 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_cnt == '0) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  always_ff @(posedge cpuclk) begin
    if (!nrst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (rx_done && (!hold_full || hold_take)) begin
      hold_full <= 1'b1;
      hold_data <= rx_shift;
    end else if (hold_take) begin
      hold_full <= 1'b0;
    end
  end

  // Main bus sequencer
  always_ff @(posedge cpuclk) begin
    if (!nrst) m_state <= M_CMD;
    else       m_state <= m_next;
  end

  always_comb begin
    m_next    = m_state;
    hold_take = 1'b0;
    cmd_err   = 1'b0;
    tx_load   = 1'b0;
    case (m_state)
      M_CMD: if (hold_full) begin
        hold_take = 1'b1;
        if (hold_data[6:4] != 3'b000) cmd_err = 1'b1;
        else if (hold_data[7])        m_next  = M_TX_WAIT;
        else                          m_next  = M_DATA_WAIT;
      end
      M_DATA_WAIT: if (hold_full) begin
        hold_take = 1'b1;
        m_next    = M_SETUP;
      end
      M_TX_WAIT:   if (!tx_busy) m_next = M_SETUP;
      M_SETUP:     if (phase_cnt == '0) m_next = M_STROBE;
      M_STROBE:    if (phase_cnt == '0) m_next = M_HOLD;
      M_HOLD:      m_next = is_read ? M_RESP : M_CMD;
      M_RESP: begin
        tx_load = 1'b1;
        m_next  = M_RESP_WAIT;
      end
      M_RESP_WAIT: if (!tx_busy) m_next = M_CMD;
      default:     m_next = M_CMD;
    endcase
  end

  always_ff @(posedge cpuclk) begin
    if (!nrst) begin
      is_read   <= 1'b0;
      cmd_addr  <= '0;
      addr_q    <= '0;
      wdata     <= '0;
      rdata     <= '0;
      phase_cnt <= '0;
    end else begin
      if (m_state == M_CMD && hold_full) begin
        is_read  <= hold_data[7];
        cmd_addr <= hold_data[3:0];
      end
      if (m_state == M_DATA_WAIT && hold_full) wdata <= hold_data;
      if (m_next == M_SETUP && m_state != M_SETUP) begin
        phase_cnt <= SETUP_RELOAD;
        addr_q    <= cmd_addr;
      end else if (m_state == M_SETUP && m_next == M_STROBE) begin
        phase_cnt <= STROBE_RELOAD;
      end else if (phase_cnt != '0) begin
        phase_cnt <= phase_cnt - 1'b1;
      end
      if (m_state == M_STROBE && phase_cnt == '0 && is_read) rdata <= bus_data;
    end
  end

  assign bus_ncs  = !(m_state inside {M_SETUP, M_STROBE, M_HOLD});
  assign bus_nwr  = !(m_state == M_STROBE && !is_read);
  assign bus_nrd  = !(m_state == M_STROBE && is_read);
  assign bus_addr = addr_q;
  assign data_oe  = !is_read && !bus_ncs;
  assign bus_data = data_oe ? wdata : 8'bz;
  assign busy     = (m_state != M_CMD);

  always_ff @(posedge cpuclk) begin
    if (!nrst) err <= 1'b0;
    else       err <= rx_frame_err | rx_overrun | cmd_err;
  end

  // Transmitter
  always_ff @(posedge cpuclk) begin
    if (!nrst) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: if (tx_cnt == '0) tx_next = TX_DATA;
      TX_DATA:  if (tx_cnt == '0 && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_cnt == '0) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge cpuclk) begin
    if (!nrst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_cnt == '0) tx_cnt <= BAUD_RELOAD;
      else                                     tx_cnt <= tx_cnt - 1'b1;
      if (tx_load) begin
        tx_shift <= rdata;
        tx_bit   <= '0;
      end else if (tx_state == TX_DATA && tx_cnt == '0) begin
        tx_shift <= {1'b1, tx_shift[7:1]};
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  assign tx_busy    = (tx_state != TX_IDLE);
  assign txd_serial = (tx_state == TX_START) ? 1'b0 :
                      (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

endmodule

// File: tb/tb_serial_bus_master.sv
// Bench for serial_bus_master: host UART driver, peripheral responder, bus and TX
// monitors, and a register-map model that predicts every bus cycle and response byte.
module tb_serial_bus_master;
  localparam int BAUD = 208;

  typedef struct {
    logic [3:0] addr;
    logic       addr_chg;
    logic [7:0] d0;
    logic [7:0] ds;
    logic       rd;
    logic       wr;
    logic       both;
    int         ncs_len;
    int         str_first;
    int         str_len;
    logic       last_low;
    logic       tx_busy;
  } bus_rec_t;

  typedef struct {
    logic [7:0] b;
    logic       start_ok;
    logic       stop_ok;
    int         lat;
  } tx_rec_t;

  logic       cpuclk = 1'b0;
  logic       nrst = 1'b0;
  logic       rxd = 1'b1;
  logic       txd_serial, bus_ncs, bus_nwr, bus_nrd, busy, err;
  logic [3:0] bus_addr;
  wire  [7:0] bus_data;

  logic [7:0] periph_mem [16];
  logic [7:0] model_mem  [16];
  bus_rec_t   bus_q[$];
  tx_rec_t    tx_q[$];

  int   checks = 0, failures = 0;
  int   cyc = 0, last_rise_cyc = 0;
  int   err_cnt = 0, err_wide = 0, err_mark = 0, stray = 0;
  logic tx_active = 1'b0;
  logic err_prev = 1'b0;

  always #5 cpuclk = ~cpuclk;
  always @(posedge cpuclk) cyc++;

  assign bus_data = bus_nrd ? 8'hzz : periph_mem[bus_addr];

  serial_bus_master #(.BAUD_DIV(BAUD), .SETUP_CYCLES(1), .STROBE_CYCLES(4)) dut (
    .cpuclk(cpuclk), .nrst(nrst), .rxd_serial(rxd), .txd_serial(txd_serial),
    .bus_ncs(bus_ncs), .bus_nwr(bus_nwr), .bus_nrd(bus_nrd), .bus_addr(bus_addr),
    .bus_data(bus_data), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin : bus_mon
    int len;
    bus_rec_t cur;
    len = 0;
    cur = '{default: '0};
    forever begin
      @(negedge cpuclk);
      if (bus_ncs && (!bus_nwr || !bus_nrd)) stray++;
      if (!bus_ncs) begin
        if (len == 0) begin
          cur = '{default: '0};
          cur.addr      = bus_addr;
          cur.d0        = bus_data;
          cur.str_first = -1;
          cur.tx_busy   = tx_active;
        end
        if (bus_addr != cur.addr) cur.addr_chg = 1'b1;
        if (!bus_nwr) begin
          cur.wr = 1'b1;
          cur.ds = bus_data;
          periph_mem[bus_addr] = bus_data;
        end
        if (!bus_nrd) cur.rd = 1'b1;
        if (!bus_nwr && !bus_nrd) cur.both = 1'b1;
        if (!bus_nwr || !bus_nrd) begin
          if (cur.str_first < 0) cur.str_first = len;
          cur.str_len++;
        end
        cur.last_low = !bus_nwr || !bus_nrd;
        len++;
      end else if (len != 0) begin
        cur.ncs_len = len;
        bus_q.push_back(cur);
        len = 0;
        last_rise_cyc = cyc;
      end
    end
  end

  initial begin : tx_mon
    tx_rec_t t;
    t = '{default: '0};
    forever begin
      @(negedge cpuclk);
      if (nrst && !txd_serial) begin
        tx_active = 1'b1;
        t.lat = cyc - last_rise_cyc;
        repeat (BAUD / 2) @(negedge cpuclk);
        t.start_ok = !txd_serial;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge cpuclk);
          t.b[i] = txd_serial;
        end
        repeat (BAUD) @(negedge cpuclk);
        t.stop_ok = txd_serial;
        tx_q.push_back(t);
        repeat (BAUD / 2) @(negedge cpuclk);
        tx_active = 1'b0;
      end
    end
  end

  initial begin : err_mon
    forever begin
      @(negedge cpuclk);
      if (nrst && err) begin
        err_cnt++;
        if (err_prev) err_wide++;
      end
      err_prev = err;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BAUD) @(negedge cpuclk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BAUD) @(negedge cpuclk);
    end
    rxd = stop;
    repeat (BAUD) @(negedge cpuclk);
    rxd = 1'b1;
  endtask

  task automatic settle();
    int n;
    repeat (300) @(negedge cpuclk);
    n = 0;
    while ((busy || tx_active) && n < 8000) begin
      @(negedge cpuclk);
      n++;
    end
    chk("settle_in_time", n < 8000, 1);
    repeat (10) @(negedge cpuclk);
  endtask

  task automatic check_rec(input string tag, input bus_rec_t r, input logic rd,
                           input logic [3:0] addr, input logic [7:0] wd);
    chk({tag, "_addr"}, r.addr, addr);
    chk({tag, "_addr_stable"}, r.addr_chg, 0);
    chk({tag, "_is_rd"}, r.rd, rd);
    chk({tag, "_is_wr"}, r.wr, !rd);
    chk({tag, "_both_strobes"}, r.both, 0);
    chk({tag, "_ncs_len"}, r.ncs_len, 6);
    chk({tag, "_strobe_first"}, r.str_first, 1);
    chk({tag, "_strobe_len"}, r.str_len, 4);
    chk({tag, "_strobe_last"}, r.last_low, 0);
    chk({tag, "_tx_idle_at_start"}, r.tx_busy, 0);
    if (!rd) begin
      chk({tag, "_data_first"}, r.d0, wd);
      chk({tag, "_data_strobe"}, r.ds, wd);
    end
  endtask

  task automatic check_tx(input string tag, input tx_rec_t t, input logic [7:0] exp);
    chk({tag, "_resp_byte"}, t.b, exp);
    chk({tag, "_resp_start"}, t.start_ok, 1);
    chk({tag, "_resp_stop"}, t.stop_ok, 1);
  endtask

  // One command's expected outcome: at most one bus cycle, one response byte, err count
  task automatic expect_txn(input string tag, input logic has_bus, input logic rd,
                            input logic [3:0] addr, input logic [7:0] d, input int err_delta);
    bus_rec_t r;
    tx_rec_t  t;
    chk({tag, "_bus_cycles"}, bus_q.size(), has_bus);
    chk({tag, "_resp_count"}, tx_q.size(), has_bus && rd);
    chk({tag, "_err_pulses"}, err_cnt - err_mark, err_delta);
    if (has_bus && bus_q.size() > 0) begin
      r = bus_q.pop_front();
      check_rec(tag, r, rd, addr, d);
    end
    if (has_bus && rd && tx_q.size() > 0) begin
      t = tx_q.pop_front();
      check_tx(tag, t, d);
      chk({tag, "_resp_latency"}, t.lat >= 1 && t.lat <= 2, 1);
    end
    bus_q.delete();
    tx_q.delete();
  endtask

  initial begin : watchdog
    repeat (150000) @(posedge cpuclk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         n, kind;
    logic [3:0] a;
    logic [7:0] d;
    logic [2:0] hi;
    bus_rec_t   r;
    tx_rec_t    t;

    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      periph_mem[i] = d;
      model_mem[i]  = d;
    end

    repeat (5) @(negedge cpuclk);
    chk("rst_txd", txd_serial, 1);
    chk("rst_ncs", bus_ncs, 1);
    chk("rst_nwr", bus_nwr, 1);
    chk("rst_nrd", bus_nrd, 1);
    chk("rst_addr", bus_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    nrst = 1'b1;
    repeat (20) @(negedge cpuclk);

    err_mark = err_cnt;
    send_frame(8'h09, 1'b1);
    send_frame(8'h03, 1'b1);
    model_mem[9] = 8'h03;
    settle();
    expect_txn("wr09", 1, 0, 4'h9, 8'h03, 0);

    periph_mem[8] = 8'hA5;
    model_mem[8]  = 8'hA5;
    err_mark = err_cnt;
    send_frame(8'h88, 1'b1);
    settle();
    expect_txn("rd88", 1, 1, 4'h8, 8'hA5, 0);

    err_mark = err_cnt;
    send_frame(8'h09, 1'b0);
    settle();
    expect_txn("frame_err", 0, 0, 4'h0, 8'h00, 1);

    err_mark = err_cnt;
    send_frame(8'h30, 1'b1);
    settle();
    expect_txn("bad_cmd30", 0, 0, 4'h0, 8'h00, 1);

    err_mark = err_cnt;
    send_frame(8'h88, 1'b1);
    settle();
    expect_txn("rd88_after_bad", 1, 1, 4'h8, model_mem[8], 0);

    periph_mem[1] = 8'h3C; model_mem[1] = 8'h3C;
    periph_mem[2] = 8'hC3; model_mem[2] = 8'hC3;
    err_mark = err_cnt;
    send_frame(8'h81, 1'b1);
    send_frame(8'h82, 1'b1);
    settle();
    chk("b2b_bus_cycles", bus_q.size(), 2);
    chk("b2b_resp_count", tx_q.size(), 2);
    chk("b2b_err_pulses", err_cnt - err_mark, 0);
    if (bus_q.size() == 2 && tx_q.size() == 2) begin
      r = bus_q.pop_front();
      check_rec("b2b_first", r, 1, 4'h1, 8'h00);
      r = bus_q.pop_front();
      check_rec("b2b_second", r, 1, 4'h2, 8'h00);
      t = tx_q.pop_front();
      check_tx("b2b_first", t, model_mem[1]);
      t = tx_q.pop_front();
      check_tx("b2b_second", t, model_mem[2]);
    end
    bus_q.delete();
    tx_q.delete();

    err_mark = err_cnt;
    rxd = 1'b0;
    repeat (50) @(negedge cpuclk);
    rxd = 1'b1;
    settle();
    expect_txn("glitch", 0, 0, 4'h0, 8'h00, 0);

    for (int k = 0; k < 6; k++) begin
      kind = $urandom_range(0, 2);
      a    = 4'($urandom);
      d    = 8'($urandom);
      err_mark = err_cnt;
      if (kind == 0) begin
        send_frame({4'h0, a}, 1'b1);
        send_frame(d, 1'b1);
        model_mem[a] = d;
        settle();
        expect_txn("rnd_wr", 1, 0, a, d, 0);
      end else if (kind == 1) begin
        send_frame({4'h8, a}, 1'b1);
        settle();
        expect_txn("rnd_rd", 1, 1, a, model_mem[a], 0);
      end else begin
        hi = 3'($urandom_range(1, 7));
        send_frame({d[7], hi, a}, 1'b1);
        settle();
        expect_txn("rnd_bad", 0, 0, a, 8'h00, 1);
      end
    end

    err_mark = err_cnt;
    fork
      begin
        send_frame(8'h0C, 1'b1);
        send_frame(8'h5A, 1'b1);
      end
    join_none
    n = 0;
    while (bus_nwr && n < 5000) begin
      @(negedge cpuclk);
      n++;
    end
    chk("rst_mid_nwr_seen", n < 5000, 1);
    @(negedge cpuclk);
    nrst = 1'b0;
    @(posedge cpuclk);
    #1;
    chk("rst_mid_nwr", bus_nwr, 1);
    chk("rst_mid_ncs", bus_ncs, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_txd", txd_serial, 1);
    @(negedge cpuclk);
    nrst = 1'b1;
    model_mem[12] = 8'h5A;
    repeat (400) @(negedge cpuclk);
    chk("rst_mid_no_resp", tx_q.size(), 0);
    chk("rst_mid_err", err_cnt - err_mark, 0);
    bus_q.delete();
    tx_q.delete();

    err_mark = err_cnt;
    send_frame(8'h83, 1'b1);
    settle();
    expect_txn("rd_after_rst", 1, 1, 4'h3, model_mem[3], 0);

    chk("err_width", err_wide, 0);
    chk("stray_strobes", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
